// File: rtl/bus_source_select_pkg.sv
// Shared definitions for the bus source selector: source codes, FSM states and
// the code-to-one-hot helper used to form the output-enable vector.
package bus_source_select_pkg;

    localparam int unsigned CODE_W  = 4;
    localparam int unsigned NUM_SRC = 12;

    // Source codes shared with the load-enable decoder
    localparam logic [CODE_W-1:0] SRC_NONE        = 4'd0;
    localparam logic [CODE_W-1:0] SRC_STR_POINTER = 4'd1;
    localparam logic [CODE_W-1:0] SRC_MEM_RDATA   = 4'd2;
    localparam logic [CODE_W-1:0] SRC_AC          = 4'd3;
    localparam logic [CODE_W-1:0] SRC_MAR         = 4'd4;
    localparam logic [CODE_W-1:0] SRC_MDR         = 4'd5;
    localparam logic [CODE_W-1:0] SRC_PR1         = 4'd6;
    localparam logic [CODE_W-1:0] SRC_PR2         = 4'd7;
    localparam logic [CODE_W-1:0] SRC_PR3         = 4'd8;
    localparam logic [CODE_W-1:0] SRC_COL         = 4'd9;
    localparam logic [CODE_W-1:0] SRC_ROW         = 4'd10;
    localparam logic [CODE_W-1:0] SRC_R1          = 4'd11;
    localparam logic [CODE_W-1:0] SRC_R2          = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRIVE = 2'd2
    } state_e;

    function automatic logic code_is_mapped(input logic [CODE_W-1:0] code);
        return (code >= SRC_STR_POINTER) && (code <= SRC_R2);
    endfunction

    // Bit index is code - 1; unmapped codes give an all-zero vector
    function automatic logic [NUM_SRC-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
        logic [NUM_SRC-1:0] oh;
        oh = '0;
        if (code_is_mapped(code)) begin
            oh[code - SRC_STR_POINTER] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/bus_source_select_edge_detect.sv
// Rising-edge detector for a clk-synchronous level: registers the level and
// flags the cycle where the current sample is high and the previous was low.
module bus_source_select_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise_c,
    output logic level_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise_c = level & ~level_q;

endmodule

// File: rtl/bus_source_select.sv
// Read-side bus source selector: latches a source code, then on a drive request
// snapshots the selected register onto the bus with a one-hot output enable.
module bus_source_select
    import bus_source_select_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CODE_W-1:0]   sel,
    input  logic                en_sel,
    input  logic                en_drive,
    input  logic [DATA_W-1:0]   str_pointer_q,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [DATA_W-1:0]   ac_q,
    input  logic [DATA_W-1:0]   mar_q,
    input  logic [DATA_W-1:0]   mdr_q,
    input  logic [DATA_W-1:0]   pr1_q,
    input  logic [DATA_W-1:0]   pr2_q,
    input  logic [DATA_W-1:0]   pr3_q,
    input  logic [DATA_W-1:0]   col_q,
    input  logic [DATA_W-1:0]   row_q,
    input  logic [DATA_W-1:0]   r1_q,
    input  logic [DATA_W-1:0]   r2_q,
    output logic [DATA_W-1:0]   bus_data,
    output logic                bus_valid,
    output logic [NUM_SRC-1:0]  bus_oe,
    output logic                sel_err,
    output logic [CNT_W-1:0]    drive_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic sel_rise_c;
    logic drive_rise_c;
    logic en_sel_q;
    logic en_drive_q;

    bus_source_select_edge_detect u_sel_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level   (en_sel),
        .rise_c  (sel_rise_c),
        .level_q (en_sel_q)
    );

    bus_source_select_edge_detect u_drive_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level   (en_drive),
        .rise_c  (drive_rise_c),
        .level_q (en_drive_q)
    );

    state_e              state_q;
    state_e              state_d;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   code_d;
    logic [DATA_W-1:0]   src_c;
    logic [DATA_W-1:0]   bus_data_d;
    logic                bus_valid_d;
    logic [NUM_SRC-1:0]  bus_oe_d;
    logic                sel_err_d;
    logic [CNT_W-1:0]    drive_cnt_d;

    // Source mux keyed on the code in effect this edge (a same-edge en_sel wins)
    always_comb begin
        src_c = '0;
        case (code_d)
            SRC_STR_POINTER: src_c = str_pointer_q;
            SRC_MEM_RDATA:   src_c = mem_rdata;
            SRC_AC:          src_c = ac_q;
            SRC_MAR:         src_c = mar_q;
            SRC_MDR:         src_c = mdr_q;
            SRC_PR1:         src_c = pr1_q;
            SRC_PR2:         src_c = pr2_q;
            SRC_PR3:         src_c = pr3_q;
            SRC_COL:         src_c = col_q;
            SRC_ROW:         src_c = row_q;
            SRC_R1:          src_c = r1_q;
            SRC_R2:          src_c = r2_q;
            default:         src_c = '0;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        code_d      = sel_rise_c ? sel : code_q;
        bus_data_d  = bus_data;
        bus_valid_d = bus_valid;
        bus_oe_d    = bus_oe;
        sel_err_d   = sel_err;
        drive_cnt_d = drive_cnt;

        case (state_q)
            IDLE, ARMED: begin
                if (drive_rise_c) begin
                    state_d     = DRIVE;
                    bus_data_d  = src_c;
                    bus_valid_d = 1'b1;
                    bus_oe_d    = code_to_onehot(code_d);
                    sel_err_d   = ~code_is_mapped(code_d);
                end else if (sel_rise_c) begin
                    state_d = ARMED;
                end
            end
            DRIVE: begin
                if (!en_drive) begin
                    state_d     = ARMED;
                    bus_data_d  = '0;
                    bus_valid_d = 1'b0;
                    bus_oe_d    = '0;
                    sel_err_d   = 1'b0;
                    if (drive_cnt != CNT_MAX) begin
                        drive_cnt_d = drive_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                bus_data_d  = '0;
                bus_valid_d = 1'b0;
                bus_oe_d    = '0;
                sel_err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= SRC_NONE;
            bus_data  <= '0;
            bus_valid <= 1'b0;
            bus_oe    <= '0;
            sel_err   <= 1'b0;
            drive_cnt <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            bus_data  <= bus_data_d;
            bus_valid <= bus_valid_d;
            bus_oe    <= bus_oe_d;
            sel_err   <= sel_err_d;
            drive_cnt <= drive_cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_source_select.sv
// Self-checking bench for bus_source_select: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_bus_source_select;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sel;
    logic        en_sel;
    logic        en_drive;
    logic [15:0] srcv [1:12];
    logic [15:0] bus_data;
    logic        bus_valid;
    logic [11:0] bus_oe;
    logic        sel_err;
    logic [7:0]  drive_cnt;

    int checks;
    int failures;

    // Reference model state
    logic [3:0]  m_code;
    logic        m_driving;
    logic [15:0] m_bus;
    logic        m_valid;
    logic [11:0] m_oe;
    logic        m_err;
    logic [7:0]  m_cnt;
    logic        m_psel;
    logic        m_pdrv;

    bus_source_select #(.DATA_W(16), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sel           (sel),
        .en_sel        (en_sel),
        .en_drive      (en_drive),
        .str_pointer_q (srcv[1]),
        .mem_rdata     (srcv[2]),
        .ac_q          (srcv[3]),
        .mar_q         (srcv[4]),
        .mdr_q         (srcv[5]),
        .pr1_q         (srcv[6]),
        .pr2_q         (srcv[7]),
        .pr3_q         (srcv[8]),
        .col_q         (srcv[9]),
        .row_q         (srcv[10]),
        .r1_q          (srcv[11]),
        .r2_q          (srcv[12]),
        .bus_data      (bus_data),
        .bus_valid     (bus_valid),
        .bus_oe        (bus_oe),
        .sel_err       (sel_err),
        .drive_cnt     (drive_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_code = 4'd0; m_driving = 1'b0; m_bus = 16'd0; m_valid = 1'b0;
        m_oe = 12'd0; m_err = 1'b0; m_cnt = 8'd0; m_psel = 1'b0; m_pdrv = 1'b0;
    endtask

    // One clock of the behavioural rules, evaluated on the inputs seen at the edge
    task automatic model_step();
        logic mapped;
        if (en_sel && !m_psel) m_code = sel;
        if (m_driving) begin
            if (!en_drive) begin
                m_driving = 1'b0; m_valid = 1'b0; m_bus = 16'd0; m_oe = 12'd0; m_err = 1'b0;
                if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
            end
        end else if (en_drive && !m_pdrv) begin
            mapped    = (m_code >= 4'd1) && (m_code <= 4'd12);
            m_driving = 1'b1;
            m_valid   = 1'b1;
            m_bus     = mapped ? srcv[m_code] : 16'd0;
            m_oe      = mapped ? (12'd1 << (m_code - 4'd1)) : 12'd0;
            m_err     = !mapped;
        end
        m_psel = en_sel;
        m_pdrv = en_drive;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bus_data"},  32'(bus_data),  32'(m_bus));
        chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(m_valid));
        chk({tag, ".bus_oe"},    32'(bus_oe),    32'(m_oe));
        chk({tag, ".sel_err"},   32'(sel_err),   32'(m_err));
        chk({tag, ".drive_cnt"}, 32'(drive_cnt), 32'(m_cnt));
        chk({tag, ".oe_onehot"}, 32'($countones(bus_oe) <= (bus_valid ? 1 : 0)), 32'd1);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0; sel = 4'd0; en_sel = 1'b0; en_drive = 1'b0;
        for (int i = 1; i <= 12; i++) srcv[i] = 16'(i * 16'h1111);
        model_reset();

        #12;
        chk("rst.bus_data",  32'(bus_data),  32'd0);
        chk("rst.bus_valid", 32'(bus_valid), 32'd0);
        chk("rst.bus_oe",    32'(bus_oe),    32'd0);
        chk("rst.sel_err",   32'(sel_err),   32'd0);
        chk("rst.drive_cnt", 32'(drive_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Drive from IDLE uses code 0
        en_drive = 1'b1; tick("idle_drv");
        chk("idle_drv.err", 32'(sel_err), 32'd1);
        chk("idle_drv.valid", 32'(bus_valid), 32'd1);
        en_drive = 1'b0; tick("idle_rel");
        chk("idle_rel.cnt", 32'(drive_cnt), 32'd1);

        // Snapshot held over a 3-clock drive while the source changes
        sel = 4'd6; srcv[6] = 16'h00A5; en_sel = 1'b1; tick("pr1_sel");
        en_sel = 1'b0; en_drive = 1'b1; tick("pr1_d1");
        chk("pr1_d1.data", 32'(bus_data), 32'h00A5);
        chk("pr1_d1.oe", 32'(bus_oe), 32'h020);
        tick("pr1_d2");
        srcv[6] = 16'h0001; tick("pr1_d3");
        chk("pr1_d3.data", 32'(bus_data), 32'h00A5);
        en_drive = 1'b0; tick("pr1_rel");

        // Same-edge select and drive
        sel = 4'hC; srcv[12] = 16'h1234; en_sel = 1'b1; en_drive = 1'b1; tick("r2_same");
        chk("r2_same.data", 32'(bus_data), 32'h1234);
        chk("r2_same.oe", 32'(bus_oe), 32'h800);
        en_sel = 1'b0; en_drive = 1'b0; tick("r2_rel");

        // Reselect during drive, then re-drive on the new code
        sel = 4'd5; srcv[5] = 16'h0F0F; en_sel = 1'b1; tick("mdr_sel");
        en_sel = 1'b0; en_drive = 1'b1; tick("mdr_drv");
        sel = 4'd9; en_sel = 1'b1; tick("mdr_resel");
        chk("mdr_resel.data", 32'(bus_data), 32'h0F0F);
        en_sel = 1'b0; srcv[9] = 16'h0042; en_drive = 1'b0; tick("mdr_rel");
        en_drive = 1'b1; tick("col_drv");
        chk("col_drv.data", 32'(bus_data), 32'h0042);
        chk("col_drv.oe", 32'(bus_oe), 32'h100);
        en_drive = 1'b0; tick("col_rel");

        // Unmapped code
        sel = 4'hE; en_sel = 1'b1; tick("e_sel");
        en_sel = 1'b0; en_drive = 1'b1; tick("e_drv");
        chk("e_drv.err", 32'(sel_err), 32'd1);
        chk("e_drv.data", 32'(bus_data), 32'd0);
        en_drive = 1'b0; tick("e_rel");
        chk("e_rel.err", 32'(sel_err), 32'd0);

        // Reset in the middle of a drive
        sel = 4'd3; en_sel = 1'b1; tick("rm_sel");
        en_sel = 1'b0; en_drive = 1'b1; tick("rm_drv");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rm_async");
        en_drive = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en_drive = 1'b1; tick("rm_redrv");
        chk("rm_redrv.err", 32'(sel_err), 32'd1);
        en_drive = 1'b0; tick("rm_rel");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            en_sel   = ($urandom_range(0, 3) == 0);
            en_drive = ($urandom_range(0, 2) != 0) ? en_drive : ~en_drive;
            sel      = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) srcv[$urandom_range(1, 12)] = 16'($urandom);
            tick("rand");
        end
        en_sel = 1'b0; en_drive = 1'b0; tick("rand_end");

        // Counter saturation
        for (int i = 0; i < 260; i++) begin
            en_drive = 1'b1; tick("sat_drv");
            en_drive = 1'b0; tick("sat_rel");
        end
        chk("sat.cnt", 32'(drive_cnt), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
